mod_counter_ctrl: RTL and testbench
===================================

MOD_COUNTER_CTRL -- requirements
Module: mod_counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..8.
REQ-002 The block SHALL have parameter MODULUS, default 10: count modulus, legal range 2..2^WIDTH.
REQ-003 The block SHALL have port C, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port R, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port EN, input, 1 bit: count enable.
REQ-006 The block SHALL have port UP, input, 1 bit: direction; 1 = up, 0 = down.
REQ-007 The block SHALL have port LD, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port LD_VAL, input, WIDTH bits: load value.
REQ-009 The block SHALL have port SNAP_REQ, input, 1 bit: snapshot request.
REQ-010 The block SHALL have port SNAP_ACK, input, 1 bit: snapshot consumed.
REQ-011 The block SHALL have port Q, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port Qbar, output, WIDTH bits: bitwise complement of Q.
REQ-013 The block SHALL have port TC, output, 1 bit: registered terminal-count (wrap) pulse.
REQ-014 The block SHALL have port SNAP_VAL, output, WIDTH bits: captured count.
REQ-015 The block SHALL have port SNAP_VLD, output, 1 bit: SNAP_VAL valid.

Function
REQ-016 All state SHALL update only on the rising edge of C, except on reset.
REQ-017 Per-edge priority SHALL be LD, then EN; when neither is high, Q holds.
REQ-018 When LD=1, Q SHALL become LD_VAL if LD_VAL < MODULUS, else MODULUS-1 (clamp); TC=0 for that edge, whatever EN is.
REQ-019 When LD=0, EN=1, UP=1: Q SHALL become Q+1, or 0 when Q = MODULUS-1.
REQ-020 When LD=0, EN=1, UP=0: Q SHALL become Q-1, or MODULUS-1 when Q = 0.
REQ-021 TC SHALL be 1 for exactly the one cycle following an edge on which a wrap in REQ-019/REQ-020 occurred, and 0 otherwise.
REQ-022 On consecutive wraps, e.g. MODULUS=2 counting continuously, TC SHALL remain high for each cycle after a wrapping edge.
REQ-023 Qbar SHALL equal ~Q at all times, including during reset.
REQ-024 The snapshot FSM SHALL have two states: IDLE and HOLD.
REQ-025 In IDLE, when SNAP_REQ=1 at an edge, SNAP_VAL SHALL capture Q as it was before that edge, SNAP_VLD SHALL go to 1, and the state SHALL go to HOLD.
REQ-026 In HOLD, SNAP_VAL SHALL stay stable and SNAP_REQ SHALL be ignored.
REQ-027 In HOLD, SNAP_ACK=1 at an edge SHALL clear SNAP_VLD and return the FSM to IDLE.
REQ-028 A SNAP_REQ on the same edge as the accepting SNAP_ACK SHALL be dropped.
REQ-029 SNAP_ACK while in IDLE SHALL have no effect.
REQ-030 Counting, loading and TC SHALL operate independently of snapshot state.

Reset
REQ-031 R=1 SHALL immediately, without waiting for C, force Q=0, Qbar=all ones, TC=0, SNAP_VAL=0, SNAP_VLD=0 and FSM=IDLE.
REQ-032 While R=1, all other inputs SHALL be ignored.
REQ-033 The first active edge after R falls SHALL be processed normally.
REQ-034 Reset asserted mid-operation, such as in HOLD or during a TC pulse, SHALL abort it with no residual pulse.

Verification
REQ-035 Reset, then EN=1, UP=1 for 12 edges -> Q = 1..9, 0, 1, 2; TC high only in the cycle after the 9->0 edge; Qbar = ~Q throughout.
REQ-036 From Q=0, EN=1, UP=0 -> Q=9 and a TC pulse; then 2 more edges -> Q=7, TC=0.
REQ-037 LD=1, LD_VAL=13, EN=1 -> Q=9, TC=0; then LD=1, LD_VAL=4 -> Q=4.
REQ-038 At Q=6, SNAP_REQ=1 while counting up -> SNAP_VAL=6, SNAP_VLD=1 and stays 6 over 5 further edges; a second SNAP_REQ is ignored; SNAP_ACK -> SNAP_VLD=0 next cycle; a SNAP_REQ on the same edge is dropped.
REQ-039 Assert R between clock edges while in HOLD with Q=5 -> Q=0, SNAP_VLD=0, TC=0 before the next edge; after release, normal count resumes from 0.

Source files
------------

// File: rtl/mod_counter_ctrl.sv
// Modulo-N up/down counter with synchronous clamped load, a registered wrap pulse,
// and a two-state snapshot register that holds a captured count until acknowledged.
module mod_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] LD_VAL,
  input  logic             SNAP_REQ,
  input  logic             SNAP_ACK,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC,
  output logic [WIDTH-1:0] SNAP_VAL,
  output logic             SNAP_VLD
);

  // One extra bit so MODULUS = 2**WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] snap_q;
  snap_state_t      state_q, state_d;
  logic             capture;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (LD) begin
      count_d = ({1'b0, LD_VAL} < MOD_EXT) ? LD_VAL : TOP;
    end else if (EN) begin
      if (UP) begin
        if (count_q == TOP) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = TOP;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // An ACK that accepts in HOLD returns to IDLE; a REQ on that same edge is not seen.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (SNAP_REQ) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (SNAP_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      snap_q  <= '0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      state_q <= state_d;
      if (capture) snap_q <= count_q;
    end
  end

  assign Q        = count_q;
  assign Qbar     = ~count_q;
  assign TC       = tc_q;
  assign SNAP_VAL = snap_q;
  assign SNAP_VLD = (state_q == HOLD);

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Randomized and directed bench for mod_counter_ctrl: a decimal counter (4b, mod 10)
// and a mod-2 counter (2b) share stimulus and are compared against an arithmetic model.
module tb_mod_counter_ctrl;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       EN = 1'b0, UP = 1'b0, LD = 1'b0, SNAP_REQ = 1'b0, SNAP_ACK = 1'b0;
  logic [3:0] ld_val_a = '0;
  logic [1:0] ld_val_b = '0;

  logic [3:0] q_a, qbar_a, sv_a;
  logic       tc_a, vld_a;
  logic [1:0] q_b, qbar_b, sv_b;
  logic       tc_b, vld_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 C = ~C;

  mod_counter_ctrl #(.WIDTH(4), .MODULUS(10)) dut_a (
    .C(C), .R(R), .EN(EN), .UP(UP), .LD(LD), .LD_VAL(ld_val_a),
    .SNAP_REQ(SNAP_REQ), .SNAP_ACK(SNAP_ACK),
    .Q(q_a), .Qbar(qbar_a), .TC(tc_a), .SNAP_VAL(sv_a), .SNAP_VLD(vld_a)
  );

  mod_counter_ctrl #(.WIDTH(2), .MODULUS(2)) dut_b (
    .C(C), .R(R), .EN(EN), .UP(UP), .LD(LD), .LD_VAL(ld_val_b),
    .SNAP_REQ(SNAP_REQ), .SNAP_ACK(SNAP_ACK),
    .Q(q_b), .Qbar(qbar_b), .TC(tc_b), .SNAP_VAL(sv_b), .SNAP_VLD(vld_b)
  );

  typedef struct {
    int q;
    bit tc;
    int sv;
    bit vld;
  } model_t;

  model_t mdl[2];
  int     mods[2]  = '{10, 2};
  int     masks[2] = '{15, 3};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.q = 0; m.tc = 1'b0; m.sv = 0; m.vld = 1'b0;
    return m;
  endfunction

  // Behaviour of one clock edge, from the counting and snapshot rules.
  function automatic model_t step(model_t m, int mod, bit ld, bit en, bit up,
                                  int lv, bit req, bit ack);
    model_t n = m;
    n.tc = 1'b0;
    if (ld) begin
      n.q = (lv < mod) ? lv : mod - 1;
    end else if (en) begin
      if (up) begin
        n.q  = (m.q + 1) % mod;
        n.tc = (m.q + 1 == mod);
      end else begin
        n.q  = (m.q + mod - 1) % mod;
        n.tc = (m.q == 0);
      end
    end
    if (!m.vld && req) begin
      n.sv  = m.q;
      n.vld = 1'b1;
    end else if (m.vld && ack) begin
      n.vld = 1'b0;
    end
    return n;
  endfunction

  task automatic compare(input string tag);
    check({tag, " a.Q"},        int'(q_a),    mdl[0].q);
    check({tag, " a.Qbar"},     int'(qbar_a), (~mdl[0].q) & masks[0]);
    check({tag, " a.TC"},       int'(tc_a),   int'(mdl[0].tc));
    check({tag, " a.SNAP_VAL"}, int'(sv_a),   mdl[0].sv);
    check({tag, " a.SNAP_VLD"}, int'(vld_a),  int'(mdl[0].vld));
    check({tag, " b.Q"},        int'(q_b),    mdl[1].q);
    check({tag, " b.Qbar"},     int'(qbar_b), (~mdl[1].q) & masks[1]);
    check({tag, " b.TC"},       int'(tc_b),   int'(mdl[1].tc));
    check({tag, " b.SNAP_VAL"}, int'(sv_b),   mdl[1].sv);
    check({tag, " b.SNAP_VLD"}, int'(vld_b),  int'(mdl[1].vld));
  endtask

  task automatic drive_random();
    logic [7:0] lv;
    lv       = 8'($urandom);
    LD       = ($urandom_range(0, 9) == 0);
    EN       = ($urandom_range(0, 9) < 7);
    UP       = 1'($urandom);
    ld_val_a = lv[3:0];
    ld_val_b = lv[1:0];
    SNAP_REQ = ($urandom_range(0, 4) == 0);
    SNAP_ACK = ($urandom_range(0, 9) < 3);
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic cycle(input string tag, input bit ld, input bit en, input bit up,
                       input logic [7:0] lv, input bit req, input bit ack);
    LD = ld; EN = en; UP = up; SNAP_REQ = req; SNAP_ACK = ack;
    ld_val_a = lv[3:0];
    ld_val_b = lv[1:0];
    @(posedge C);
    mdl[0] = step(mdl[0], mods[0], ld, en, up, int'(lv[3:0]), req, ack);
    mdl[1] = step(mdl[1], mods[1], ld, en, up, int'(lv[1:0]), req, ack);
    @(negedge C);
    compare(tag);
  endtask

  // Reset raised between edges must take effect at once; random inputs during it are ignored.
  task automatic do_reset(input string tag);
    #2;
    R = 1'b1;
    drive_random();
    #1;
    mdl[0] = model_reset();
    mdl[1] = model_reset();
    compare({tag, " async"});
    @(posedge C);
    #1;
    compare({tag, " held"});
    @(negedge C);
    R = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, en, up, req, ack;
    logic [7:0] lv;

    mdl[0] = model_reset();
    mdl[1] = model_reset();
    #1;
    compare("por");
    @(negedge C);
    compare("por_held");
    R = 1'b0;

    for (int i = 0; i < 12; i++) cycle("count_up", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    check("up12 Q", int'(q_a), 2);

    cycle("load0", 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    cycle("down_wrap", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check("down_wrap Q", int'(q_a), 9);
    check("down_wrap TC", int'(tc_a), 1);
    cycle("down", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cycle("down", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check("down2 Q", int'(q_a), 7);
    check("down2 TC", int'(tc_a), 0);

    cycle("load_clamp", 1'b1, 1'b1, 1'b1, 8'd13, 1'b0, 1'b0);
    check("clamp Q", int'(q_a), 9);
    check("clamp TC", int'(tc_a), 0);
    cycle("load4", 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0);
    check("load4 Q", int'(q_a), 4);
    cycle("load_top_over_tc", 1'b1, 1'b1, 1'b1, 8'd15, 1'b0, 1'b0);

    cycle("pre_snap", 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0);
    cycle("pre_snap", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    cycle("snap", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
    check("snap VAL", int'(sv_a), 6);
    check("snap VLD", int'(vld_a), 1);
    for (int i = 0; i < 5; i++) cycle("hold", 1'b0, 1'b1, 1'b1, 8'd0, i[0], 1'b0);
    check("hold VAL", int'(sv_a), 6);
    cycle("ack_req", 1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
    check("ack VLD", int'(vld_a), 0);
    cycle("after_ack", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    check("dropped VLD", int'(vld_a), 0);
    cycle("idle_ack", 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1);

    cycle("r39_load", 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0);
    cycle("r39_snap", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("r39 hold VLD", int'(vld_a), 1);
    do_reset("r39_reset");
    check("r39 reset Q", int'(q_a), 0);
    cycle("r39_resume", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    check("r39 resume Q", int'(q_a), 1);

    cycle("tc_abort_load", 1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0);
    cycle("tc_abort_wrap", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    check("tc_abort pulse", int'(tc_a), 1);
    do_reset("tc_abort_reset");
    cycle("tc_abort_after", 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rand_reset");
      end else begin
        lv  = 8'($urandom);
        ld  = ($urandom_range(0, 9) == 0);
        en  = ($urandom_range(0, 9) < 7);
        up  = 1'($urandom);
        req = ($urandom_range(0, 4) == 0);
        ack = ($urandom_range(0, 9) < 3);
        cycle("rand", ld, en, up, lv, req, ack);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
